// File: rtl/sevenseg_scan.sv
// rtl/sevenseg_scan.sv - multiplexed four-digit seven-segment MM:SS scanner
//
// Purpose: scans four BCD digits onto a multiplexed seven-segment display,
// one digit per REFRESH_COUNT-cycle slot. All four digits are captured as one
// snapshot at each frame start so the display never shows a torn count.
// Also blanks a leading minute-tens zero and blinks the colon while running.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   sec_ones     BCD seconds ones   (digit 0, an[0])
//   sec_tens     BCD seconds tens   (digit 1, an[1])
//   min_ones     BCD minutes ones   (digit 2, an[2], carries the colon)
//   min_tens     BCD minutes tens   (digit 3, an[3], blankable)
//   running      stopwatch running; colon blinks when high, steady when low
//   blank_lz     blank digit 3 when it is zero
//   an           one-hot digit enable
//   seg          segments {g,f,e,d,c,b,a}
//   dp           colon, only in the digit-2 slot
//   frame_start  one-cycle pulse on the first cycle of each frame
module sevenseg_scan #(
   parameter int REFRESH_COUNT = 50000,
   parameter int BLINK_FRAMES  = 125,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] sec_ones,
   input  logic [3:0] sec_tens,
   input  logic [3:0] min_ones,
   input  logic [3:0] min_tens,
   input  logic       running,
   input  logic       blank_lz,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_start
);

   localparam int PW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_COUNT - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
   localparam logic [1:0]    SLOT_COLON = 2'd2;
   localparam logic [1:0]    SLOT_LAST  = 2'd3;

   logic [PW-1:0]     pre;
   logic [1:0]        idx;
   logic [3:0][3:0]   snap;
   logic              snap_lz;
   logic [BW-1:0]     blink_cnt;
   logic              blink_phase;

   logic              frame_tick;
   logic              frame_end;
   logic [3:0][3:0]   in_digits;
   logic [3:0][3:0]   eff_digits;
   logic              eff_lz;
   logic [3:0]        cur_digit;
   logic [3:0]        an_c;
   logic [6:0]        seg_c;
   logic              dp_c;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      case (d)
         4'd0:    bcd_to_seg = 7'h3F;
         4'd1:    bcd_to_seg = 7'h06;
         4'd2:    bcd_to_seg = 7'h5B;
         4'd3:    bcd_to_seg = 7'h4F;
         4'd4:    bcd_to_seg = 7'h66;
         4'd5:    bcd_to_seg = 7'h6D;
         4'd6:    bcd_to_seg = 7'h7D;
         4'd7:    bcd_to_seg = 7'h07;
         4'd8:    bcd_to_seg = 7'h7F;
         4'd9:    bcd_to_seg = 7'h6F;
         default: bcd_to_seg = 7'h40;
      endcase
   endfunction

   assign frame_tick = (pre == '0) && (idx == 2'd0);
   assign frame_end  = (pre == PRE_LAST) && (idx == SLOT_LAST);
   assign in_digits  = {min_tens, min_ones, sec_tens, sec_ones};

   // On the snapshot edge the output register sees the digits being captured,
   // so the whole first slot of a frame shows the new snapshot.
   assign eff_digits = frame_tick ? in_digits : snap;
   assign eff_lz     = frame_tick ? blank_lz : snap_lz;
   assign cur_digit  = eff_digits[idx];

   always_comb begin
      an_c  = 4'b0001 << idx;
      seg_c = bcd_to_seg(cur_digit);
      dp_c  = 1'b0;
      if (idx == SLOT_COLON) begin
         dp_c = running ? blink_phase : 1'b1;
      end
      if ((idx == SLOT_LAST) && eff_lz && (cur_digit == 4'd0)) begin
         an_c  = 4'b0000;
         seg_c = 7'h00;
      end
   end

   // Scan position and snapshot
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre     <= '0;
         idx     <= 2'd0;
         snap    <= '0;
         snap_lz <= 1'b0;
      end else begin
         if (pre == PRE_LAST) begin
            pre <= '0;
            idx <= idx + 2'd1;
         end else begin
            pre <= pre + 1'b1;
         end
         if (frame_tick) begin
            snap    <= in_digits;
            snap_lz <= blank_lz;
         end
      end
   end

   // Colon blink: counts frames while running, held cleared when stopped
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (!running) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_end) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // Output registers, polarity applied here
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an          <= {4{ACTIVE_LOW}};
         seg         <= {7{ACTIVE_LOW}};
         dp          <= ACTIVE_LOW;
         frame_start <= 1'b0;
      end else begin
         an          <= an_c ^ {4{ACTIVE_LOW}};
         seg         <= seg_c ^ {7{ACTIVE_LOW}};
         dp          <= dp_c ^ ACTIVE_LOW;
         frame_start <= frame_tick;
      end
   end

endmodule
